// File: rtl/alu_if.sv
// ALU bus: the driver supplies operands, command, valid bits and enable;
// the ALU returns RES and the COUT/OFLOW/G/E/L/ERR flags.
interface alu_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0] OPA;
   logic [DATA_WIDTH-1:0] OPB;
   logic [CMD_WIDTH-1:0]  CMD;
   logic                  MODE;
   logic                  CIN;
   logic [1:0]            INP_VALID;
   logic                  CE;
   logic [DATA_WIDTH+1:0] RES;
   logic                  COUT;
   logic                  OFLOW;
   logic                  G;
   logic                  E;
   logic                  L;
   logic                  ERR;

   modport master (
      output OPA, OPB, CMD, MODE, CIN, INP_VALID, CE,
      input  RES, COUT, OFLOW, G, E, L, ERR
   );

   modport slave (
      input  OPA, OPB, CMD, MODE, CIN, INP_VALID, CE,
      output RES, COUT, OFLOW, G, E, L, ERR
   );
endinterface

// File: rtl/alu_core.sv
// Registered ALU with split-operand collection, timeout and 2-stage multiply.
// Ports: CLK, RESET (async, active low), bus (alu_if.slave: inputs/results).
module alu_core #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic CLK,
   input  logic RESET,
   alu_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int EW = DATA_WIDTH + 1;
   localparam int RW = DATA_WIDTH + 2;
   localparam int SW = $clog2(DATA_WIDTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

   typedef struct packed {
      logic [DW-1:0]        a;
      logic [DW-1:0]        b;
      logic [CMD_WIDTH-1:0] cmd;
      logic                 mode;
      logic                 cin;
      logic                 err;
   } op_t;

   function automatic logic a_only(logic [CMD_WIDTH-1:0] c, logic m);
      int n = int'(c);
      return m ? (n == 4 || n == 5) : (n == 6 || n == 8 || n == 9);
   endfunction

   function automatic logic b_only(logic [CMD_WIDTH-1:0] c, logic m);
      int n = int'(c);
      return m ? (n == 6 || n == 7) : (n == 7 || n == 10 || n == 11);
   endfunction

   function automatic logic is_mul(op_t o);
      return !o.err && o.mode && (int'(o.cmd) == 9 || int'(o.cmd) == 10);
   endfunction

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [DW-1:0]        lat_opnd_q, lat_opnd_d;
   logic [CMD_WIDTH-1:0] lat_cmd_q, lat_cmd_d;
   logic                 lat_mode_q, lat_mode_d;
   logic                 lat_cin_q, lat_cin_d;
   logic                 issue;
   op_t                  iss;
   op_t                  s1_q;
   logic                 s1_v_q, s2_v_q;
   logic [RW-1:0]        s2_res_q;
   logic [RW-1:0]        res_q;
   logic [5:0]           fl_q;
   logic                 stall;

   // A non-multiply sitting behind a multiply must wait one edge while
   // the multiply result drains; the front end is frozen for that edge.
   assign stall = s1_v_q && s2_v_q && !is_mul(s1_q);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      lat_opnd_d = lat_opnd_q;
      lat_cmd_d  = lat_cmd_q;
      lat_mode_d = lat_mode_q;
      lat_cin_d  = lat_cin_q;
      issue      = 1'b0;
      iss        = '{a: bus.OPA, b: bus.OPB, cmd: bus.CMD,
                     mode: bus.MODE, cin: bus.CIN, err: 1'b0};
      if (!stall) begin
         unique case (state_q)
            IDLE: begin
               if (bus.INP_VALID != 2'b00) begin
                  if (a_only(bus.CMD, bus.MODE)) begin
                     issue   = 1'b1;
                     iss.err = !bus.INP_VALID[0];
                  end else if (b_only(bus.CMD, bus.MODE)) begin
                     issue   = 1'b1;
                     iss.err = !bus.INP_VALID[1];
                  end else if (bus.INP_VALID == 2'b11) begin
                     issue = 1'b1;
                  end else begin
                     lat_opnd_d = bus.INP_VALID[0] ? bus.OPA : bus.OPB;
                     lat_cmd_d  = bus.CMD;
                     lat_mode_d = bus.MODE;
                     lat_cin_d  = bus.CIN;
                     timer_d    = '0;
                     state_d    = bus.INP_VALID[0] ? WAIT_B : WAIT_A;
                  end
               end
            end
            WAIT_A, WAIT_B: begin
               iss.cmd  = lat_cmd_q;
               iss.mode = lat_mode_q;
               iss.cin  = lat_cin_q;
               if (state_q == WAIT_B) iss.a = lat_opnd_q;
               else                   iss.b = lat_opnd_q;
               if ((state_q == WAIT_B) ? bus.INP_VALID[1]
                                       : bus.INP_VALID[0]) begin
                  issue   = 1'b1;
                  state_d = IDLE;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  issue   = 1'b1;
                  iss.err = 1'b1;
                  state_d = IDLE;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   logic [EW-1:0] xa, xb, xc, sum;
   logic [DW-1:0] lg, rol_v, ror_v;
   logic [SW-1:0] sh;
   logic          rot_bad, bad, cy, bw, cg, ce_q, cl;
   logic [RW-1:0] nm_res, ma, mb, mul_res;
   logic [5:0]    nm_fl;

   assign xa      = {1'b0, s1_q.a};
   assign xb      = {1'b0, s1_q.b};
   assign xc      = EW'(s1_q.cin);
   assign sh      = s1_q.b[SW-1:0];
   assign rot_bad = (s1_q.b >> SW) != '0;
   assign rol_v   = (s1_q.a << sh) | (s1_q.a >> (DW - int'(sh)));
   assign ror_v   = (s1_q.a >> sh) | (s1_q.a << (DW - int'(sh)));

   always_comb begin
      sum  = '0;
      lg   = '0;
      cy   = 1'b0;
      bw   = 1'b0;
      cg   = 1'b0;
      ce_q = 1'b0;
      cl   = 1'b0;
      bad  = s1_q.err;
      if (s1_q.mode) begin
         unique case (int'(s1_q.cmd))
            0: begin sum = xa + xb; cy = sum[DW]; end
            1: begin sum = xa - xb; cy = sum[DW]; bw = sum[DW]; end
            2: begin sum = xa + xb + xc; cy = sum[DW]; end
            3: begin sum = xa - xb - xc; cy = sum[DW]; bw = sum[DW]; end
            4: sum = xa + EW'(1);
            5: sum = xa - EW'(1);
            6: sum = xb + EW'(1);
            7: sum = xb - EW'(1);
            8: begin
               cg   = s1_q.a > s1_q.b;
               ce_q = s1_q.a == s1_q.b;
               cl   = s1_q.a < s1_q.b;
            end
            9, 10: ;
            default: bad = 1'b1;
         endcase
      end else begin
         unique case (int'(s1_q.cmd))
            0:  lg = s1_q.a & s1_q.b;
            1:  lg = ~(s1_q.a & s1_q.b);
            2:  lg = s1_q.a | s1_q.b;
            3:  lg = ~(s1_q.a | s1_q.b);
            4:  lg = s1_q.a ^ s1_q.b;
            5:  lg = ~(s1_q.a ^ s1_q.b);
            6:  lg = ~s1_q.a;
            7:  lg = ~s1_q.b;
            8:  lg = s1_q.a >> 1;
            9:  lg = s1_q.a << 1;
            10: lg = s1_q.b >> 1;
            11: lg = s1_q.b << 1;
            12: begin lg = rol_v; bad = bad | rot_bad; end
            13: begin lg = ror_v; bad = bad | rot_bad; end
            default: bad = 1'b1;
         endcase
      end
      nm_res = s1_q.mode ? {1'b0, sum} : {2'b00, lg};
      nm_fl  = {cy, bw, cg, ce_q, cl, 1'b0};
      if (bad) begin
         nm_res = '0;
         nm_fl  = 6'b000001;
      end
   end

   always_comb begin
      if (int'(s1_q.cmd) == 9) begin
         ma = RW'(s1_q.a) + RW'(1);
         mb = RW'(s1_q.b) + RW'(1);
      end else begin
         ma = RW'({s1_q.a[DW-2:0], 1'b0});
         mb = RW'(s1_q.b);
      end
      mul_res = ma * mb;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         lat_opnd_q <= '0;
         lat_cmd_q  <= '0;
         lat_mode_q <= 1'b0;
         lat_cin_q  <= 1'b0;
         s1_q       <= '0;
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_res_q   <= '0;
         res_q      <= '0;
         fl_q       <= '0;
      end else if (bus.CE) begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         lat_opnd_q <= lat_opnd_d;
         lat_cmd_q  <= lat_cmd_d;
         lat_mode_q <= lat_mode_d;
         lat_cin_q  <= lat_cin_d;
         if (!stall) begin
            s1_v_q <= issue;
            s1_q   <= iss;
         end
         s2_v_q   <= s1_v_q && is_mul(s1_q);
         s2_res_q <= mul_res;
         if (s2_v_q) begin
            res_q <= s2_res_q;
            fl_q  <= '0;
         end else if (s1_v_q && !is_mul(s1_q)) begin
            res_q <= nm_res;
            fl_q  <= nm_fl;
         end
      end
   end

   assign bus.RES   = res_q;
   assign bus.COUT  = fl_q[5];
   assign bus.OFLOW = fl_q[4];
   assign bus.G     = fl_q[3];
   assign bus.E     = fl_q[2];
   assign bus.L     = fl_q[1];
   assign bus.ERR   = fl_q[0];
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_alu_core;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [9:0] res;
      logic       cout;
      logic       oflow;
      logic       g;
      logic       e;
      logic       l;
      logic       err;
   } exp_t;

   typedef struct {
      int   at;
      exp_t x;
   } item_t;

   logic CLK;
   logic RESET;
   alu_if #(.DATA_WIDTH(8), .CMD_WIDTH(4)) bus ();

   alu_core #(.DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int    checks = 0;
   int    failures = 0;
   int    en_edge = 0;
   item_t q[$];
   exp_t  cur = '0;
   int    pend = 0;
   int    p_opnd, p_cmd, p_cin, waited;
   bit    p_mode;
   int    mul_edge = -100;
   int    stall_edge = -100;

   always @(posedge CLK)
      if (RESET && bus.CE) en_edge <= en_edge + 1;

   function automatic exp_t err_x();
      exp_t r = '0;
      r.err = 1'b1;
      return r;
   endfunction

   function automatic bit is_mul(int cmd, bit mode);
      return mode && (cmd == 9 || cmd == 10);
   endfunction

   function automatic bit need_a_only(int cmd, bit mode);
      return mode ? (cmd == 4 || cmd == 5) : (cmd == 6 || cmd == 8 || cmd == 9);
   endfunction

   function automatic bit need_b_only(int cmd, bit mode);
      return mode ? (cmd == 6 || cmd == 7) : (cmd == 7 || cmd == 10 || cmd == 11);
   endfunction

   function automatic exp_t ref_alu(int a, int b, int cmd, bit mode, int cin);
      exp_t r = '0;
      int   v = 0;
      if (mode) begin
         case (cmd)
            0: begin v = a + b; r.cout = v > 255; end
            1: begin v = a - b; r.cout = a < b; r.oflow = a < b; end
            2: begin v = a + b + cin; r.cout = v > 255; end
            3: begin v = a - b - cin; r.cout = a < b + cin; r.oflow = a < b + cin; end
            4: v = a + 1;
            5: v = a - 1;
            6: v = b + 1;
            7: v = b - 1;
            8: begin r.g = a > b; r.e = a == b; r.l = a < b; end
            9: v = (a + 1) * (b + 1);
            10: v = ((a * 2) % 256) * b;
            default: r.err = 1'b1;
         endcase
         r.res = (cmd == 9 || cmd == 10) ? 10'(v & 'h3FF) : 10'(v & 'h1FF);
      end else begin
         case (cmd)
            0: v = a & b;
            1: v = ~(a & b);
            2: v = a | b;
            3: v = ~(a | b);
            4: v = a ^ b;
            5: v = ~(a ^ b);
            6: v = ~a;
            7: v = ~b;
            8: v = a / 2;
            9: v = a * 2;
            10: v = b / 2;
            11: v = b * 2;
            12: if (b > 7) r.err = 1'b1; else v = (a << b) | (a >> (8 - b));
            13: if (b > 7) r.err = 1'b1; else v = (a >> b) | (a << (8 - b));
            default: r.err = 1'b1;
         endcase
         r.res = 10'(v & 'hFF);
      end
      if (r.err) r = err_x();
      return r;
   endfunction

   // Result lands one enabled edge after issue, two for multiply; a
   // non-multiply directly behind a multiply lands one edge later and
   // the edge between is not available for a new transaction.
   task automatic issue(int e, exp_t x, bit mul);
      item_t it;
      it.x = x;
      if (mul) begin
         it.at = e + 2;
         mul_edge = e;
      end else if (mul_edge == e - 1) begin
         it.at = e + 2;
         stall_edge = e + 1;
      end else begin
         it.at = e + 1;
      end
      q.push_back(it);
   endtask

   task automatic model_edge(int e, int iv, int a, int b, int cmd, bit mode, int cin);
      if (e == stall_edge) return;
      if (pend == 0) begin
         if (iv == 0) return;
         if (need_a_only(cmd, mode))
            issue(e, (iv & 1) != 0 ? ref_alu(a, b, cmd, mode, cin) : err_x(), 1'b0);
         else if (need_b_only(cmd, mode))
            issue(e, (iv & 2) != 0 ? ref_alu(a, b, cmd, mode, cin) : err_x(), 1'b0);
         else if (iv == 3)
            issue(e, ref_alu(a, b, cmd, mode, cin), is_mul(cmd, mode));
         else begin
            pend = iv;
            p_opnd = (iv == 1) ? a : b;
            p_cmd = cmd;
            p_mode = mode;
            p_cin = cin;
            waited = 0;
         end
      end else begin
         if (pend == 1 && (iv & 2) != 0) begin
            issue(e, ref_alu(p_opnd, b, p_cmd, p_mode, p_cin), is_mul(p_cmd, p_mode));
            pend = 0;
         end else if (pend == 2 && (iv & 1) != 0) begin
            issue(e, ref_alu(a, p_opnd, p_cmd, p_mode, p_cin), is_mul(p_cmd, p_mode));
            pend = 0;
         end else begin
            waited++;
            if (waited == TIMEOUT) begin
               issue(e, err_x(), 1'b0);
               pend = 0;
            end
         end
      end
   endtask

   task automatic compare(string name, exp_t want);
      exp_t got;
      got = {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s @edge%0d: got res=%h cout/oflow/g/e/l/err=%b, want res=%h flags=%b",
                  name, en_edge, got.res, got[5:0], want.res, want[5:0]);
      end
   endtask

   task automatic expect_now(string name, int res, bit c, bit o, bit g, bit e, bit l, bit err);
      exp_t w;
      w.res = 10'(res);
      w.cout = c;
      w.oflow = o;
      w.g = g;
      w.e = e;
      w.l = l;
      w.err = err;
      compare(name, w);
   endtask

   always @(negedge CLK) begin
      if (RESET) begin
         if (q.size() > 0 && q[0].at < en_edge) begin
            checks++;
            failures++;
            $display("FAIL lost_result: expected at edge %0d, now edge %0d", q[0].at, en_edge);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].at == en_edge) begin
            cur = q[0].x;
            void'(q.pop_front());
         end
         compare("scoreboard", cur);
      end
   end

   task automatic cyc(int iv, int a, int b, int cmd, bit mode, bit cin, bit ce);
      bus.INP_VALID = 2'(iv);
      bus.OPA = 8'(a);
      bus.OPB = 8'(b);
      bus.CMD = 4'(cmd);
      bus.MODE = mode;
      bus.CIN = cin;
      bus.CE = ce;
      if (ce) model_edge(en_edge + 1, iv, a, b, cmd, mode, int'(cin));
      @(negedge CLK);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic model_reset();
      q.delete();
      cur = '0;
      pend = 0;
      mul_edge = -100;
      stall_edge = -100;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET = 1'b0;
      bus.INP_VALID = 2'b00;
      bus.OPA = '0;
      bus.OPB = '0;
      bus.CMD = '0;
      bus.MODE = 1'b0;
      bus.CIN = 1'b0;
      bus.CE = 1'b1;
      #3;
      expect_now("reset_state", 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;

      cyc(3, 'hFF, 'h01, 0, 1'b1, 1'b0, 1'b1);
      idle(1);
      expect_now("add_ff_01", 'h100, 1, 0, 0, 0, 0, 0);

      cyc(3, 3, 4, 9, 1'b1, 1'b0, 1'b1);
      cyc(3, 'h10, 'h20, 0, 1'b1, 1'b0, 1'b1);
      expect_now("mul_hold", 'h100, 1, 0, 0, 0, 0, 0);
      idle(1);
      expect_now("mul_inc", 20, 0, 0, 0, 0, 0, 0);
      idle(1);
      expect_now("add_behind_mul", 'h30, 0, 0, 0, 0, 0, 0);

      cyc(1, 5, 0, 8, 1'b1, 1'b0, 1'b1);
      idle(3);
      cyc(2, 0, 9, 0, 1'b0, 1'b1, 1'b1);
      idle(1);
      expect_now("cmp_split", 0, 0, 0, 0, 0, 1, 0);

      cyc(1, 'hAA, 0, 4, 1'b0, 1'b0, 1'b1);
      idle(TIMEOUT);
      expect_now("no_early_timeout", 0, 0, 0, 0, 0, 1, 0);
      idle(1);
      expect_now("timeout_err", 0, 0, 0, 0, 0, 0, 1);
      cyc(3, 'hF0, 'h3C, 0, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("and_after_timeout", 'h30, 0, 0, 0, 0, 0, 0);

      cyc(3, 'h81, 'h10, 12, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("rol_bad_amount", 0, 0, 0, 0, 0, 0, 1);
      cyc(3, 'h81, 'h03, 12, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("rol_3", 'h0C, 0, 0, 0, 0, 0, 0);
      cyc(3, 'h81, 'h01, 13, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("ror_1", 'hC0, 0, 0, 0, 0, 0, 0);
      cyc(3, 1, 2, 15, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("cmd15_logic", 0, 0, 0, 0, 0, 0, 1);

      cyc(3, 'h0F, 'hF0, 2, 1'b0, 1'b0, 1'b1);
      idle(1);
      expect_now("or_base", 'hFF, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1'b1, 1'b0, 1'b1);
      idle(5);
      for (int i = 0; i < 3; i++) cyc(3, 0, 7, 0, 1'b1, 1'b0, 1'b0);
      expect_now("ce_freeze", 'hFF, 0, 0, 0, 0, 0, 0);
      idle(TIMEOUT - 6);
      expect_now("timeout_extended", 'hFF, 0, 0, 0, 0, 0, 0);
      idle(2);
      expect_now("ce_timeout_err", 0, 0, 0, 0, 0, 0, 1);

      cyc(3, 5, 6, 9, 1'b1, 1'b0, 1'b1);
      #2;
      RESET = 1'b0;
      #1;
      expect_now("async_reset", 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      idle(3);
      expect_now("no_result_after_reset", 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         int r, iv, a, b, cmd;
         bit mode, cin, ce;
         r = $urandom_range(0, 7);
         iv = (r >= 4) ? 3 : r;
         a = $urandom_range(0, 255);
         b = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
         cmd = $urandom_range(0, 15);
         mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) begin
            cmd = $urandom_range(9, 10);
            mode = 1'b1;
            iv = 3;
         end
         cin = 1'($urandom_range(0, 1));
         ce = $urandom_range(0, 9) != 0;
         cyc(iv, a, b, cmd, mode, cin, ce);
      end

      idle(TIMEOUT + 4);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results still pending, want 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_core.md
# alu_core

Registered ALU that sits on the DUT end of the ALU interface bus. It consumes OPA/OPB/CMD/MODE/CIN/INP_VALID/CE from the driver side and produces RES/COUT/OFLOW/G/E/L/ERR for the monitor side. It has three further features:
- an operand-collection state machine, so operands may arrive in separate cycles, with a timeout;
- a two-stage multiply path;
- clock-enable freeze.

## Interface
- DATA_WIDTH, 8, operand width (power of two, ≥4)
- CMD_WIDTH, 4, command width
- TIMEOUT, 16, cycles allowed between first and second operand
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- OPA, OPB  in  DATA_WIDTH  operands
- CMD  in  CMD_WIDTH  operation code
- MODE  in  1  1 = arithmetic, 0 = logical
- CIN  in  1  carry in
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- CE  in  1  clock enable
- RES  out  DATA_WIDTH+2  result, zero-extended
- COUT, OFLOW, G, E, L, ERR  out  1 each  flags

## Operation
- Command set, MODE=1 (arithmetic):
  - 0 ADD, 1 SUB (OFLOW = borrow), 2 ADD_CIN, 3 SUB_CIN
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP: sets exactly one of G/E/L; RES=0
  - 9 MUL_INC = (A+1)*(B+1)
  - 10 MUL_SHL = (A<<1, truncated to DATA_WIDTH)*B
- Command set, MODE=0 (logical):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by OPB[log2(DATA_WIDTH)-1:0]
- ERR cases: any unlisted CMD/MODE pair; a rotate with any upper OPB bit set. In both cases RES=0 and all other flags are 0.
- Arithmetic widths:
  - ADD/SUB: COUT = bit DATA_WIDTH of the result.
  - Multiply results use the full DATA_WIDTH+2 bits, truncated.
  - Logical results are DATA_WIDTH wide, upper bits 0.
- Flags: every new result rewrites all flags. A flag not defined for the op is 0.
- Operand requirement by command:
  - Single-operand, A only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - Single-operand, B only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
  - Everything else needs both operands.
- FSM states IDLE, WAIT_A, WAIT_B:
  - IDLE, INP_VALID=00: no operation; outputs hold.
  - IDLE, INP_VALID covers the command's needs: issue to pipeline.
  - IDLE, single-operand command whose required bit is absent: issue an ERR result.
  - IDLE, two-operand command with only 01: latch OPA/CMD/MODE/CIN, go to WAIT_B, timer=0.
  - IDLE, two-operand command with only 10: latch OPB/CMD/MODE/CIN, go to WAIT_A, timer=0.
  - WAIT_B: the first cycle with INP_VALID[1]=1 takes OPB (OPA is ignored), issues, and returns to IDLE. CMD/MODE/CIN changes during the wait are ignored. WAIT_A is symmetric.
  - Timer increments each enabled cycle in WAIT_A or WAIT_B.
  - If the timer reaches TIMEOUT-1 with no operand: issue an ERR result and return to IDLE. An operand arriving on that same cycle wins over the timeout.
- CE=0 freezes everything: FSM, timer, latches, both pipeline stages and outputs. Inputs are not sampled.
- RESET low: FSM to IDLE, timer and pipeline cleared, RES=0, all flags 0, immediately and asynchronously. This holds mid-wait and mid-multiply; the in-flight operation is discarded.

## Timing
- Issue at enabled edge k: operands are captured into the stage-1 register.
- Non-multiply result: RES and flags are updated at enabled edge k+1.
- Multiply result: updated at enabled edge k+2. Stage 2 holds the partial result for one cycle.
- A non-multiply issued at k+1, directly behind a multiply issued at k, would collide at k+2. Resolution: the multiply result takes edge k+2 and the younger result takes edge k+3. The FSM does not accept a new issue at edge k+2 (stall one cycle), so results are never lost or reordered.
- Outputs hold between results.
- Throughput: one issue per cycle for non-multiply; a multiply costs one extra cycle.
- Split operands: the result appears one edge (two for multiply) after the edge that accepted the second operand.
- Timeout: ERR is set one edge after the timeout edge, with RES=0.

## Test plan
- MODE=1, CMD=0, OPA=0xFF, OPB=0x01, INP_VALID=11, CE=1 at edge 0 -> RES=0x100, COUT=1, all other flags 0 at edge 1.
- MODE=1, CMD=9, OPA=3, OPB=4, both valid -> RES=20 at edge 2; RES holds its previous value at edge 1; ADD issued at edge 1 lands at edge 3.
- MODE=1, CMD=8, OPA=5 with INP_VALID=01 at edge 0, then OPB=9 with INP_VALID=10 at edge 4 -> L=1, G=E=0, RES=0 at edge 5.
- MODE=0, CMD=4, INP_VALID=01 then 00 for 16 cycles -> ERR=1, RES=0 one edge after the timeout; FSM back in IDLE; next valid AND completes normally.
- MODE=0, CMD=12, OPB=0x10 -> ERR=1. Repeated with OPB=0x03, OPA=0x81 -> RES=0x0C, ERR=0. CMD=15 with MODE=0 -> ERR=1.
- CE=0 for 3 cycles in mid-WAIT_B -> timer and outputs frozen, timeout extended by 3 cycles. RESET low mid-multiply -> all outputs 0 asynchronously, no result after release.
